// File: rtl/conv1d_loader.sv
// Streams input samples and filter weights from a byte host into a conv1d CFU.
// It then reads back the accumulator and presents it as a one-cycle result pulse.
module conv1d_loader #(
   parameter int         KERNEL_LENGTH      = 8,
   parameter int         MAX_INPUT_CHANNELS = 128,
   parameter logic [6:0] IDLE_CMD           = 7'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  depth,
   output logic        busy,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic [6:0]  cmd,
   output logic [31:0] inp0,
   output logic [31:0] inp1,
   input  logic [31:0] ret,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_DEPTH,
      S_LOAD_IN,
      S_LOAD_FLT,
      S_READ_ACC,
      S_WAIT_RET,
      S_CAPTURE
   } state_t;

   localparam logic [6:0] CMD_LOAD_IN  = 7'd1;
   localparam logic [6:0] CMD_LOAD_FLT = 7'd2;
   localparam logic [6:0] CMD_SET_DEP  = 7'd5;
   localparam logic [6:0] CMD_READ_ACC = 7'd7;

   state_t      state_q, state_d;
   logic [7:0]  depth_q, depth_d;
   logic [10:0] last_q, last_d;
   logic [10:0] cnt_q, cnt_d;
   logic [6:0]  cmd_q, cmd_d;
   logic [31:0] inp0_q, inp0_d;
   logic [31:0] inp1_q, inp1_d;
   logic [31:0] result_q, result_d;
   logic        result_valid_q, result_valid_d;
   logic        error_q, error_d;
   logic        depth_ok;
   logic        accept;

   assign in_ready     = (state_q == S_LOAD_IN) || (state_q == S_LOAD_FLT);
   assign busy         = (state_q != S_IDLE);
   assign accept       = in_valid && in_ready;
   assign depth_ok     = (depth != 8'd0) && (int'(depth) <= MAX_INPUT_CHANNELS);
   assign cmd          = cmd_q;
   assign inp0         = inp0_q;
   assign inp1         = inp1_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign error        = error_q;

   always_comb begin
      state_d        = state_q;
      depth_d        = depth_q;
      last_d         = last_q;
      cnt_d          = cnt_q;
      cmd_d          = IDLE_CMD;
      inp0_d         = 32'd0;
      inp1_d         = 32'd0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      error_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (depth_ok) begin
                  depth_d = depth;
                  // Store N-1 so the wrap test is a plain equality on the counter.
                  last_d  = 11'(KERNEL_LENGTH * int'(depth) - 1);
                  state_d = S_SET_DEPTH;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_SET_DEPTH: begin
            cmd_d   = CMD_SET_DEP;
            inp1_d  = {24'd0, depth_q};
            cnt_d   = 11'd0;
            state_d = S_LOAD_IN;
         end
         S_LOAD_IN, S_LOAD_FLT: begin
            if (accept) begin
               cmd_d  = (state_q == S_LOAD_IN) ? CMD_LOAD_IN : CMD_LOAD_FLT;
               inp0_d = {21'd0, cnt_q};
               inp1_d = {{24{in_data[7]}}, in_data};
               if (cnt_q == last_q) begin
                  cnt_d   = 11'd0;
                  state_d = (state_q == S_LOAD_IN) ? S_LOAD_FLT : S_READ_ACC;
               end else begin
                  cnt_d = cnt_q + 11'd1;
               end
            end
         end
         S_READ_ACC: begin
            cmd_d   = CMD_READ_ACC;
            state_d = S_WAIT_RET;
         end
         // The CFU registers its return word while the read beat is on the bus.
         S_WAIT_RET: state_d = S_CAPTURE;
         S_CAPTURE: begin
            result_d       = ret;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         depth_q        <= 8'd0;
         last_q         <= 11'd0;
         cnt_q          <= 11'd0;
         cmd_q          <= IDLE_CMD;
         inp0_q         <= 32'd0;
         inp1_q         <= 32'd0;
         result_q       <= 32'd0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         depth_q        <= depth_d;
         last_q         <= last_d;
         cnt_q          <= cnt_d;
         cmd_q          <= cmd_d;
         inp0_q         <= inp0_d;
         inp1_q         <= inp1_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         error_q        <= error_d;
      end
   end

endmodule

// File: doc/conv1d_loader.md
CONV1D_LOADER -- requirements
Module: conv1d_loader

Interface
REQ-001 SHALL have parameter KERNEL_LENGTH, default 8, taps per channel.
REQ-002 SHALL have parameter MAX_INPUT_CHANNELS, default 128, largest legal depth.
REQ-003 SHALL have parameter IDLE_CMD, default 7'd0, command driven when no beat is issued.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to run one load/readback job.
REQ-007 SHALL have port depth  input  8  input channel count, sampled with start.
REQ-008 SHALL have port busy  output  1  high from job acceptance until result_valid or error.
REQ-009 SHALL have port in_valid  input  1  host byte stream valid.
REQ-010 SHALL have port in_ready  output  1  host byte stream ready.
REQ-011 SHALL have port in_data  input  8  signed byte: input samples first, then filter weights.
REQ-012 SHALL have port cmd  output  7  command to the conv1d CFU.
REQ-013 SHALL have port inp0  output  32  CFU address operand.
REQ-014 SHALL have port inp1  output  32  CFU value operand.
REQ-015 SHALL have port ret  input  32  CFU registered return word.
REQ-016 SHALL have port result  output  32  captured accumulator.
REQ-017 SHALL have port result_valid  output  1  one-cycle pulse, result is valid.
REQ-018 SHALL have port error  output  1  one-cycle pulse, start rejected for illegal depth.

Function
REQ-019 SHALL implement states IDLE, SET_DEPTH, LOAD_IN, LOAD_FLT, READ_ACC, WAIT_RET, CAPTURE.
REQ-020 SHALL register cmd, inp0, inp1; each issued beat is visible for exactly one cycle, then cmd returns to IDLE_CMD and inp0/inp1 to 0.
REQ-021 IDLE: start with 1 <= depth <= MAX_INPUT_CHANNELS latches depth, sets N = KERNEL_LENGTH*depth, goes to SET_DEPTH, busy=1 next cycle.
REQ-022 IDLE: start with depth 0 or > MAX_INPUT_CHANNELS pulses error next cycle, stays IDLE, issues no beat.
REQ-023 SET_DEPTH: one cycle, issues cmd=5, inp0=0, inp1=zero-extended depth, then LOAD_IN with address counter=0.
REQ-024 LOAD_IN/LOAD_FLT: in_ready=1; in_ready=0 in all other states.
REQ-025 Each in_valid&&in_ready edge issues one beat next cycle: cmd=1 (LOAD_IN) or 2 (LOAD_FLT), inp0=address counter, inp1=in_data sign-extended to 32 bits; counter then increments.
REQ-026 in_valid low leaves counter unchanged and issues no beat; gaps of any length are legal.
REQ-027 Byte accepted at counter N-1 in LOAD_IN moves to LOAD_FLT with counter=0; at N-1 in LOAD_FLT moves to READ_ACC.
REQ-028 READ_ACC: one cycle, issues cmd=7, inp0=0, inp1=0, then WAIT_RET.
REQ-029 WAIT_RET: one cycle, allows CFU to register ret; CAPTURE samples ret into result.
REQ-030 Timing: cmd=7 visible in cycle c implies ret sampled at end of cycle c+1, result_valid high in cycle c+2, busy low same cycle, state IDLE.
REQ-031 start while busy SHALL be ignored, no side effect.
REQ-032 result SHALL hold its value until the next CAPTURE.
REQ-033 Address counter SHALL be 11 bits wide; never exceeds N-1 (max 1023).

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, cmd=IDLE_CMD, inp0=0, inp1=0, in_ready=0, busy=0, result=0, result_valid=0, error=0, counter=0.
REQ-035 Reset mid-job SHALL abandon the job; no further beats issued after rst_n deasserts until a new start.

Verification
REQ-036 depth=1, 8 input bytes 1..8, 8 filter bytes -1, CFU model ret=0x1234 -> cmd=5/inp1=1, cmd=1 addr 0..7, cmd=2 addr 0..7 inp1=0xFFFFFFFF, cmd=7, result=0x1234 pulse 2 cycles after cmd=7.
REQ-037 depth=128, stream with in_valid toggling every other cycle -> 1024 cmd=1 beats addr 0..1023, 1024 cmd=2 beats, no lost or duplicated address.
REQ-038 start with depth=0 and depth=129 -> error pulse each, cmd stays 0, busy stays 0.
REQ-039 start asserted during LOAD_IN -> ignored, beat sequence unchanged.
REQ-040 rst_n low after 5 filter bytes -> all outputs reset values asynchronously; new start depth=2 completes normally with 16+16 beats.
REQ-041 in_data=0x80 -> inp1=0xFFFFFF80; in_data=0x7F -> inp1=0x0000007F.
